// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Busy covers the fixed-latency MUL/DIV window; Out always shows committed HI or LO.
module mdu_hilo #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HiLoSel,
   output logic        Busy,
   output logic [31:0] Out
);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   localparam logic [3:0] MUL_LD = 4'(MULT_CYC);
   localparam logic [3:0] DIV_LD = 4'(DIV_CYC);

   // Handshake: a request is taken only when Start=1 and Busy=0 before the edge;
   // requests seen while Busy=1 are dropped, the hazard unit is expected to stall.
   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [31:0] op_a, op_b;
   logic        sgn;
   logic [31:0] hi, lo;
   logic        latch, commit, wr_hi, wr_lo;

   logic [63:0] prod_s, prod_u;
   logic [31:0] mag_a, mag_b, uq, ur, quo, rem;

   assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
   assign prod_u = {32'd0, op_a} * {32'd0, op_b};

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
   always_comb begin
      mag_a = op_a;
      mag_b = op_b;
      uq    = 32'd0;
      ur    = 32'd0;
      quo   = 32'hFFFF_FFFF;
      rem   = op_a;
      if (op_b != 32'd0) begin
         if (sgn) begin
            mag_a = op_a[31] ? (32'd0 - op_a) : op_a;
            mag_b = op_b[31] ? (32'd0 - op_b) : op_b;
            uq    = mag_a / mag_b;
            ur    = mag_a % mag_b;
            quo   = (op_a[31] ^ op_b[31]) ? (32'd0 - uq) : uq;
            rem   = op_a[31] ? (32'd0 - ur) : ur;
         end else begin
            quo = op_a / op_b;
            rem = op_a % op_b;
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      latch   = 1'b0;
      commit  = 1'b0;
      wr_hi   = 1'b0;
      wr_lo   = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               case (Op)
                  3'b000, 3'b001: begin
                     state_n = MUL;
                     cnt_n   = MUL_LD;
                     latch   = 1'b1;
                  end
                  3'b010, 3'b011: begin
                     state_n = DIV;
                     cnt_n   = DIV_LD;
                     latch   = 1'b1;
                  end
                  3'b100:  wr_hi = 1'b1;
                  3'b101:  wr_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         MUL, DIV: begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) begin
               commit  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         op_a  <= 32'd0;
         op_b  <= 32'd0;
         sgn   <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (latch) begin
            op_a <= A;
            op_b <= B;
            sgn  <= ~Op[0];
         end
         if (wr_hi) hi <= A;
         if (wr_lo) lo <= A;
         if (commit) begin
            if (state == MUL) begin
               hi <= sgn ? prod_s[63:32] : prod_u[63:32];
               lo <= sgn ? prod_s[31:0]  : prod_u[31:0];
            end else begin
               hi <= rem;
               lo <= quo;
            end
         end
      end
   end

   assign Busy = (state != IDLE);
   assign Out  = HiLoSel ? hi : lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: hand-computed HI/LO results, Busy length and
// the ignore/abort corner cases.
module tb_mdu_hilo;

   logic        clk;
   logic        reset;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        HiLoSel;
   logic        Busy;
   logic [31:0] Out;

   int n_cmp;
   int n_bad;

   mdu_hilo dut (
      .clk     (clk),
      .reset   (reset),
      .Start   (Start),
      .Op      (Op),
      .A       (A),
      .B       (B),
      .HiLoSel (HiLoSel),
      .Busy    (Busy),
      .Out     (Out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      HiLoSel = 1'b1;
      #1 check({tag, "_hi"}, Out, exp_hi);
      HiLoSel = 1'b0;
      #1 check({tag, "_lo"}, Out, exp_lo);
   endtask

   // Request sampled on the next rising edge; returns #1 after that edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      @(posedge clk);
      #1 Start = 1'b0;
   endtask

   // Counts sampled cycles with Busy high; bounded so a stuck Busy still ends.
   task automatic wait_idle(input string tag, input int exp_cyc);
      int cyc;
      cyc = 0;
      @(negedge clk);
      while (Busy === 1'b1 && cyc < 40) begin
         cyc++;
         @(negedge clk);
      end
      check({tag, "_busy_len"}, 32'(cyc), 32'(exp_cyc));
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      issue(op, a, b);
      wait_idle(tag, n);
      check_hilo(tag, exp_hi, exp_lo);
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      reset   = 1'b0;
      Start   = 1'b0;
      Op      = 3'b000;
      A       = 32'd0;
      B       = 32'd0;
      HiLoSel = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check_hilo("rst", 32'd0, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("rel_busy", {31'd0, Busy}, 32'd0);
      check_hilo("rel", 32'd0, 32'd0);

      run_op("mult",  3'b000, 32'd3, 32'hFFFF_FFFE, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", 3'b001, 32'd3, 32'hFFFF_FFFE, 5, 32'h0000_0002, 32'hFFFF_FFFA);
      run_op("div",   3'b010, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu",  3'b011, 32'd7, 32'd2, 10, 32'd1, 32'd3);
      run_op("div0",  3'b010, 32'h1234_5678, 32'd0, 10, 32'h1234_5678, 32'hFFFF_FFFF);
      run_op("divov", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
      run_op("divu_big", 3'b011, 32'hFFFF_FFF9, 32'd2, 10, 32'd1, 32'h7FFF_FFFC);

      // Back-to-back MTHI then MTLO.
      @(negedge clk);
      Start = 1'b1;
      Op    = 3'b100;
      A     = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 Op = 3'b101;
      A = 32'h0BAD_F00D;
      check("mthi_busy", {31'd0, Busy}, 32'd0);
      @(posedge clk);
      #1 Start = 1'b0;
      check("mtlo_busy", {31'd0, Busy}, 32'd0);
      @(negedge clk);
      check_hilo("mt", 32'hDEAD_BEEF, 32'h0BAD_F00D);

      // Reserved opcodes change nothing.
      issue(3'b110, 32'h5555_5555, 32'd1);
      issue(3'b111, 32'h6666_6666, 32'd1);
      @(negedge clk);
      check("nop_busy", {31'd0, Busy}, 32'd0);
      check_hilo("nop", 32'hDEAD_BEEF, 32'h0BAD_F00D);

      // MTLO and operand changes during a MULT must be ignored.
      issue(3'b000, 32'h10, 32'h20);
      @(posedge clk);
      #1 Start = 1'b1;
      Op = 3'b101;
      A  = 32'h1;
      B  = 32'h7;
      @(posedge clk);
      #1 Start = 1'b0;
      A = 32'h5;
      wait_idle("busy_ign", 3);
      check_hilo("busy_ign", 32'd0, 32'h200);

      // Start on the commit edge is dropped; the commit wins.
      issue(3'b000, 32'd3, 32'hFFFF_FFFE);
      repeat (3) @(posedge clk);
      @(posedge clk);
      #1 Start = 1'b1;
      Op = 3'b100;
      A  = 32'h0000_AAAA;
      @(posedge clk);
      #1 Start = 1'b0;
      check("edge_busy", {31'd0, Busy}, 32'd0);
      @(negedge clk);
      check_hilo("edge", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      // Reset in the middle of a DIV aborts without a later commit.
      issue(3'b010, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1 check("abort_busy", {31'd0, Busy}, 32'd0);
      check_hilo("abort", 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check("post_abort_busy", {31'd0, Busy}, 32'd0);
      check_hilo("post_abort", 32'd0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers for the 32-bit MIPS datapath in EX.
- Executes MULT/MULTU/DIV/DIVU over a fixed number of cycles and reports Busy to the hazard unit.
- Supports MTHI/MTLO writes and drives the selected HI/LO value on Out.
- Out feeds the third data input (Sel=2'b10) of the downstream 3:1 writeback/result mux for MFHI/MFLO.

Parameters:
- MULT_CYC, 5, cycles Busy stays high for MULT/MULTU (legal range 1..15).
- DIV_CYC, 10, cycles Busy stays high for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request to execute Op; sampled on the rising clk edge.
- Op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- A  input  32  rs operand.
- B  input  32  rt operand.
- HiLoSel  input  1  Out select: 1 = HI, 0 = LO.
- Busy  output  1  high while a mult/div is in flight.
- Out  output  32  HiLoSel ? HI : LO.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, state=IDLE, counter=0, operand latches=0. Out=0 immediately.
- Out is combinational from the HI/LO registers and HiLoSel. It always shows committed values, never partial results.
- FSM states are IDLE, MUL, DIV. A 4-bit down-counter is held for each op.
- IDLE, Start=1, Op=MULT/MULTU at edge t:
  - Latch A and B; counter=MULT_CYC; go to MUL.
  - Busy=1 from edge t through edge t+MULT_CYC.
- IDLE, Start=1, Op=DIV/DIVU: same as above with DIV_CYC; go to DIV.
- MUL/DIV: counter decrements each edge. At edge t+N (counter reaches 0) commit the result to HI/LO, Busy=0, return to IDLE.
  - Result latency is N cycles; the result is visible on Out from edge t+N.
- Arithmetic, computed from the latched operands only (A/B changes during Busy have no effect):
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (latched B=0): HI = latched A, LO = 32'hFFFFFFFF. Busy still lasts DIV_CYC.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0. Must not produce X.
- MTHI/MTLO in IDLE: HI or LO = A at the same edge; Busy stays 0; single cycle.
- Start while Busy=1 (any Op, including MTHI/MTLO): ignored. The hazard unit guarantees stall; the block does not queue.
- Start with Op 110/111: no state change.
- Start=1 on the same edge the counter reaches 0: the commit happens and Start is ignored. The new request is accepted only when Busy=0 before the edge.
- Reset asserted mid-operation: abort immediately, HI/LO cleared, no commit on release.
- Counter never wraps: a loaded value of 0 is impossible under legal parameters.

Test Plan:
- Reset release, HiLoSel toggled -> Out=0, Busy=0. Reassert reset during a DIV at cycle 4 -> Busy=0 at once, HI=LO=0.
- MULT A=3, B=0xFFFFFFFE (-2) -> Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7, B=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=2 -> LO=3, HI=1.
- DIV A=0x12345678, B=0 -> HI=0x12345678, LO=0xFFFFFFFF after 10 cycles. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- MTHI A=0xDEADBEEF, then MTLO A=0x0BADF00D on consecutive cycles -> Busy stays 0; HiLoSel=1 gives 0xDEADBEEF and HiLoSel=0 gives 0x0BADF00D one edge later.
- Issue MULT, then at cycle 2 assert Start MTLO A=0x1 and change A/B -> MTLO ignored; result uses the original operands; LO reflects the product, not 0x1.
